// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe : two-stage pipelined ALU with an architectural carry/zero flag
//            register, flag-conditional ops and valid/ready flow control.
//
// Optional feature macro: ALU_SUB_EN
//   defined   -> opcode 111 performs SUB (a - b, C = 1 means no borrow)
//   undefined -> opcode 111 is a NOP (one beat, result_we=0, flags unchanged)
//
// Ports
//   clk         in   1      clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   in_valid    in   1      op/a/b valid this cycle
//   in_ready    out  1      op accepted when in_valid & in_ready
//   op          in   3      opcode
//   a, b        in   WIDTH  operands
//   out_valid   out  1      result/result_we valid
//   out_ready   in   1      result consumed when out_valid & out_ready
//   result      out  WIDTH  computed value (0 for skipped/non-writing ops)
//   result_we   out  1      1 = write back result
//   carry_flag  out  1      architectural C flag
//   zero_flag   out  1      architectural Z flag
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. A producer holding valid must keep its payload stable until the
// transfer; ready may be asserted independently of valid.
// -----------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_we,
  output logic             carry_flag,
  output logic             zero_flag
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADC  = 3'b001;
  localparam logic [2:0] OP_ADZ  = 3'b010;
  localparam logic [2:0] OP_CMP  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NDC  = 3'b101;
  localparam logic [2:0] OP_NDZ  = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  // Stage S1: captured operation
  logic             r_s1_valid;
  logic [2:0]       r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;

  // Stage S2: result beat and architectural flags
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_we;
  logic             r_c;
  logic             r_z;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_accept;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_nand;
  logic [WIDTH-1:0] w_res;
  logic             w_we;
  logic             w_c;
  logic             w_z;

  assign w_s2_adv = ~r_s2_valid | out_ready;
  assign w_s1_adv = r_s1_valid & w_s2_adv;
  assign in_ready = ~r_s1_valid | w_s2_adv;
  assign w_accept = in_valid & in_ready;

  assign w_sum  = {1'b0, r_s1_a} + {1'b0, r_s1_b};
  assign w_diff = {1'b0, r_s1_a} + {1'b0, ~r_s1_b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_nand = ~(r_s1_a & r_s1_b);

  // Result and next flags for the op in S1. The flag register already holds
  // the effect of every older op, so conditional ops test it directly.
  // Defaults describe a skipped op: no write, result 0, flags kept.
  always_comb begin
    w_res = '0;
    w_we  = 1'b0;
    w_c   = r_c;
    w_z   = r_z;
    unique case (r_s1_op)
      OP_ADD, OP_ADC, OP_ADZ: begin
        if ((r_s1_op == OP_ADD) || (r_s1_op == OP_ADC && r_c) ||
            (r_s1_op == OP_ADZ && r_z)) begin
          w_res = w_sum[WIDTH-1:0];
          w_we  = 1'b1;
          w_c   = w_sum[WIDTH];
          w_z   = (w_sum[WIDTH-1:0] == '0);
        end
      end
      OP_CMP: begin
        w_z = (r_s1_a == r_s1_b);
      end
      OP_NAND, OP_NDC, OP_NDZ: begin
        if ((r_s1_op == OP_NAND) || (r_s1_op == OP_NDC && r_c) ||
            (r_s1_op == OP_NDZ && r_z)) begin
          w_res = w_nand;
          w_we  = 1'b1;
          w_z   = (w_nand == '0);
        end
      end
      OP_SUB: begin
`ifdef ALU_SUB_EN
        w_res = w_diff[WIDTH-1:0];
        w_we  = 1'b1;
        w_c   = w_diff[WIDTH];
        w_z   = (w_diff[WIDTH-1:0] == '0);
`else
        // NOP: defaults already describe a non-writing beat
        w_res = '0;
`endif
      end
      default: ;
    endcase
  end

`ifndef ALU_SUB_EN
  // The difference is only consumed when SUB is built in.
  logic w_unused_diff;
  assign w_unused_diff = ^w_diff;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_op    <= op;
      r_s1_a     <= a;
      r_s1_b     <= b;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_we       <= 1'b0;
      r_c        <= 1'b0;
      r_z        <= 1'b0;
    end else begin
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
      end
      // Flags move only together with an op entering S2
      if (w_s1_adv) begin
        r_result <= w_res;
        r_we     <= w_we;
        r_c      <= w_c;
        r_z      <= w_z;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign result     = r_result;
  assign result_we  = r_we;
  assign carry_flag = r_c;
  assign zero_flag  = r_z;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe : self-checking bench for alu_pipe (WIDTH = 16).
// A sequential reference model computes each op's beat at issue time and
// pushes it into exp_q; an independent monitor pops and compares every
// consumed output beat, and checks that stalled outputs hold stable.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

  localparam int W = 16;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         result_we;
  logic         carry_flag;
  logic         zero_flag;

  alu_pipe #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .result_we  (result_we),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  // entry = {result, we, C, Z}
  logic [W+2:0] exp_q[$];
  int           n_cmp  = 0;
  int           n_fail = 0;
  logic         m_c = 1'b0;
  logic         m_z = 1'b0;
  int           rdy_mode = 0;  // 0: always ready, 1: never ready, 2: random

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Sequential reference model: plain arithmetic over the architectural
  // flags, applied in issue order.
  function automatic logic [W+2:0] model(input logic [2:0] o,
                                         input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    longint unsigned s;
    longint unsigned lim;
    logic [W-1:0]    r;
    logic            we;
    logic            run;
    lim = longint'(1) << W;
    r   = '0;
    we  = 1'b0;
    run = (o == 3'd0) || (o == 3'd4) || ((o == 3'd1 || o == 3'd5) && m_c) ||
          ((o == 3'd2 || o == 3'd6) && m_z);
    if (o == 3'd3) begin
      m_z = (x == y);
    end else if (run && o < 3'd3) begin
      s   = longint'(x) + longint'(y);
      r   = W'(s % lim);
      we  = 1'b1;
      m_c = (s >= lim);
      m_z = (r == 0);
    end else if (run) begin
      r   = ~(x & y);
      we  = 1'b1;
      m_z = (r == 0);
    end
`ifdef ALU_SUB_EN
    if (o == 3'd7) begin
      r   = W'((longint'(x) - longint'(y) + lim) % lim);
      we  = 1'b1;
      m_c = (x >= y);
      m_z = (r == 0);
    end
`endif
    return {r, we, m_c, m_z};
  endfunction

  // ---------------- out_ready driver ----------------
  always @(negedge clk) begin
    if (rdy_mode == 0)      out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = 1'b0;
    else                    out_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- driver task ----------------
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int tries, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < tries; t++) begin
      @(negedge clk);
      in_valid = 1'b1;
      op = o;
      a  = x;
      b  = y;
      #1;
      if (in_ready) begin
        exp_q.push_back(model(o, x, y));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ok = 1'b1;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic must_issue(input logic [2:0] o, input logic [W-1:0] x,
                            input logic [W-1:0] y);
    bit ok;
    issue(o, x, y, 200, ok);
    check("issue_timeout", ok, 1);
  endtask

  // ---------------- monitor ----------------
  logic         hold_v = 1'b0;
  logic [W+2:0] hold_d;

  always @(negedge clk) begin
    logic [W+2:0] got;
    logic [W+2:0] exp_v;
    #2;
    got = {result, result_we, carry_flag, zero_flag};
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_data", got, hold_d);
      end
      hold_v = out_valid && !out_ready;
      hold_d = got;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          exp_v = exp_q.pop_front();
          check("beat{res,we,c,z}", got, exp_v);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int acc;
    in_valid  = 1'b0;
    op        = '0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_we", result_we, 0);
    check("reset_carry", carry_flag, 0);
    check("reset_zero", zero_flag, 0);
    check("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // 1: basic ADD and two-cycle latency
    must_issue(3'd0, 16'd25, 16'd40);
    @(negedge clk); #2;
    check("latency_n+1_out_valid", out_valid, 0);
    @(negedge clk); #2;
    check("latency_n+2_out_valid", out_valid, 1);
    check("add_25_40_result", result, 65);

    // 2: wrap-around then carry-conditional add back-to-back
    must_issue(3'd0, ONES, 16'd1);
    must_issue(3'd1, 16'd3, 16'd4);

    // 3: compare drives Z, zero-conditional add
    must_issue(3'd3, 16'd25, 16'd40);
    must_issue(3'd2, 16'd1, 16'd1);
    must_issue(3'd3, 16'd5, 16'd5);
    must_issue(3'd2, 16'd1, 16'd1);
    // nand family
    must_issue(3'd4, ONES, ONES);
    must_issue(3'd6, 16'h00F0, 16'h0FF0);
    must_issue(3'd5, 16'h1234, 16'h5678);

    // 4: backpressure fills both stages
    repeat (4) @(negedge clk);
    rdy_mode = 1;
    acc = 0;
    issue(3'd0, 16'd100, 16'd1, 3, ok); acc += int'(ok);
    issue(3'd0, 16'hFFF0, 16'h0020, 3, ok); acc += int'(ok);
    issue(3'd1, 16'd7, 16'd8, 4, ok); acc += int'(ok);
    check("stall_accept_count", acc, 2);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    rdy_mode = 0;
    must_issue(3'd1, 16'd7, 16'd8);
    must_issue(3'd0, 16'd9, ONES);

    // 6: op 111
    must_issue(3'd0, ONES, 16'd2);           // C=1
    must_issue(3'd7, 16'd40, 16'd25);
    must_issue(3'd7, 16'd25, 16'd40);
    must_issue(3'd7, 16'd7, 16'd7);
    repeat (4) @(negedge clk);

    // 5: reset with both stages full and flags set
    rdy_mode = 1;
    issue(3'd0, ONES, 16'd1, 3, ok);
    issue(3'd0, 16'd2, 16'd3, 3, ok);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_carry", carry_flag, 0);
    check("midreset_zero", zero_flag, 0);
    exp_q.delete();
    m_c = 1'b0;
    m_z = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      check("post_reset_no_beat", out_valid, 0);
    end

    // random traffic with random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      case ($urandom_range(0, 3))
        0: x = '0;
        1: x = ONES;
        default: x = W'($urandom);
      endcase
      y = ($urandom_range(0, 3) == 0) ? x : W'($urandom_range(0, 3) == 0 ? 1 : $urandom);
      must_issue(3'($urandom_range(0, 7)), x, y);
    end

    // drain
    rdy_mode = 0;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("drain_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
